// File: rtl/cwd_pkg.sv
// Shared types and constants for the constant-weight decoder session controller.
package cwd_pkg;

  localparam int CWD_CW_W       = 16;
  localparam int CWD_MSG_W      = 8;
  localparam int CWD_FIFO_DEPTH = 4;
  localparam int CWD_WDOG_CYC   = 256;
  localparam int CWD_STAT_W     = 16;

  typedef enum logic [2:0] {
    CWD_S_IDLE  = 3'd0,
    CWD_S_DRST  = 3'd1,
    CWD_S_START = 3'd2,
    CWD_S_RUN   = 3'd3,
    CWD_S_FLUSH = 3'd4
  } cwd_state_e;

  localparam logic [1:0] CWD_OK       = 2'b00;
  localparam logic [1:0] CWD_WDOG     = 2'b01;
  localparam logic [1:0] CWD_LEFTOVER = 2'b10;
  localparam logic [1:0] CWD_UNDERRUN = 2'b11;

  function automatic logic [CWD_STAT_W-1:0] cwd_sat_inc(input logic [CWD_STAT_W-1:0] v);
    return (&v) ? v : v + CWD_STAT_W'(1);
  endfunction

endpackage

// File: rtl/cwd_cw_fifo.sv
// Codeword FIFO: array storage, head word registered into the output on each pop.
module cwd_cw_fifo #(
  parameter int W     = 16,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] head,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW:0]   wr_ptr_q, wr_ptr_d;
  logic [AW:0]   rd_ptr_q, rd_ptr_d;
  logic [W-1:0]  head_q, head_d;
  logic          push_ok;
  logic          pop_ok;

  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign push_ok = push && !full && !flush;
  assign pop_ok  = pop && !empty && !flush;
  assign head    = head_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    head_d   = head_q;
    if (flush) begin
      rd_ptr_d = wr_ptr_q;
    end else begin
      if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop_ok) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
        head_d   = mem[rd_ptr_q[AW-1:0]];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr_q[AW-1:0]] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      head_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      head_q   <= head_d;
    end
  end

endmodule

// File: rtl/cwd_decode_ctrl.sv
// Session controller for the 16-9 constant-weight decoder: job FSM, codeword FIFO, bit packer.
// Optional watchdog built when CWD_CTRL_WATCHDOG_EN is defined.
module cwd_decode_ctrl
  import cwd_pkg::*;
#(
  parameter int CW_W       = CWD_CW_W,
  parameter int MSG_W      = CWD_MSG_W,
  parameter int FIFO_DEPTH = CWD_FIFO_DEPTH,
  parameter int WDOG_CYC   = CWD_WDOG_CYC
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             job_start,
  output logic             job_busy,
  input  logic             cw_valid,
  input  logic [CW_W-1:0]  cw_data,
  output logic             cw_ready,
  output logic             dec_rst_b,
  output logic             dec_start,
  output logic             dec_fifoempty,
  output logic [CW_W-1:0]  dec_cw_word,
  input  logic             dec_readfifo,
  input  logic             dec_bin_msg,
  input  logic             dec_ready,
  input  logic             dec_done,
  output logic             msg_valid,
  output logic [MSG_W-1:0] msg_data,
  output logic             msg_last,
  output logic             stat_valid,
  output logic [15:0]      stat_bits,
  output logic [1:0]       stat_err
);

  localparam logic [2:0] ST_IDLE  = CWD_S_IDLE;
  localparam logic [2:0] ST_DRST  = CWD_S_DRST;
  localparam logic [2:0] ST_START = CWD_S_START;
  localparam logic [2:0] ST_RUN   = CWD_S_RUN;
  localparam logic [2:0] ST_FLUSH = CWD_S_FLUSH;
  localparam int NB_W = $clog2(MSG_W);

  if (WDOG_CYC < 1 || FIFO_DEPTH < 2) begin : g_bad_cfg
  end

  logic [2:0]       state_q, state_d;
  logic             drst_cnt_q, drst_cnt_d;
  logic             dec_rst_b_q, dec_rst_b_d;
  logic             dec_start_q, dec_start_d;
  logic [MSG_W-1:0] shift_q, shift_d;
  logic [NB_W-1:0]  nbits_q, nbits_d;
  logic [MSG_W-1:0] pend_q, pend_d;
  logic             pend_vld_q, pend_vld_d;
  logic [15:0]      total_q, total_d;
  logic             underrun_q, underrun_d;
  logic             wdog_hit_q, wdog_hit_d;
  logic             msg_valid_q, msg_valid_d;
  logic [MSG_W-1:0] msg_data_q, msg_data_d;
  logic             msg_last_q, msg_last_d;
  logic             stat_valid_q, stat_valid_d;
  logic [15:0]      stat_bits_q, stat_bits_d;
  logic [1:0]       stat_err_q, stat_err_d;
  logic [MSG_W-1:0] cap_word;
  logic             fifo_full, fifo_empty, fifo_push, fifo_pop, fifo_flush;
  logic             wdog_trip;

  assign cw_ready   = !fifo_full && (state_q != ST_FLUSH);
  assign fifo_push  = cw_valid && cw_ready;
  assign fifo_pop   = (state_q == ST_RUN) && dec_readfifo;
  assign fifo_flush = (state_q == ST_FLUSH);

  cwd_cw_fifo #(.W(CW_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .flush     (fifo_flush),
    .push      (fifo_push),
    .push_data (cw_data),
    .pop       (fifo_pop),
    .head      (dec_cw_word),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

`ifdef CWD_CTRL_WATCHDOG_EN
  localparam int WD_W = $clog2(WDOG_CYC + 1);
  logic [WD_W-1:0] wdog_q, wdog_d;

  // Counts only consecutive RUN cycles with queued words and no decoder activity.
  always_comb begin
    wdog_d    = '0;
    wdog_trip = 1'b0;
    if (state_q == ST_RUN && !(dec_ready || dec_readfifo || fifo_empty)) begin
      wdog_d    = wdog_q + 1'b1;
      wdog_trip = (wdog_q == WD_W'(WDOG_CYC - 1));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) wdog_q <= '0;
    else     wdog_q <= wdog_d;
  end
`else
  assign wdog_trip = 1'b0;
`endif

  always_comb begin
    cap_word = shift_q;
    for (int i = 0; i < MSG_W; i++) begin
      if (i == MSG_W - 1 - int'(nbits_q)) cap_word[i] = dec_bin_msg;
    end
  end

  always_comb begin
    state_d      = state_q;
    drst_cnt_d   = drst_cnt_q;
    shift_d      = shift_q;
    nbits_d      = nbits_q;
    pend_d       = pend_q;
    pend_vld_d   = pend_vld_q;
    total_d      = total_q;
    underrun_d   = underrun_q;
    wdog_hit_d   = wdog_hit_q;
    msg_valid_d  = 1'b0;
    msg_data_d   = msg_data_q;
    msg_last_d   = 1'b0;
    stat_valid_d = 1'b0;
    stat_bits_d  = stat_bits_q;
    stat_err_d   = stat_err_q;
    case (state_q)
      ST_IDLE: begin
        if (job_start) begin
          state_d    = ST_DRST;
          drst_cnt_d = 1'b0;
          shift_d    = '0;
          nbits_d    = '0;
          pend_vld_d = 1'b0;
          total_d    = '0;
          underrun_d = 1'b0;
          wdog_hit_d = 1'b0;
        end
      end
      ST_DRST: begin
        drst_cnt_d = 1'b1;
        if (drst_cnt_q) state_d = ST_START;
      end
      ST_START: state_d = ST_RUN;
      ST_RUN: begin
        if (dec_ready) begin
          total_d = cwd_sat_inc(total_q);
          // A completed word is held back so the one that turns out last can carry msg_last.
          if (pend_vld_q) begin
            msg_valid_d = 1'b1;
            msg_data_d  = pend_q;
            pend_vld_d  = 1'b0;
          end
          if (int'(nbits_q) == MSG_W - 1) begin
            pend_d     = cap_word;
            pend_vld_d = 1'b1;
            shift_d    = '0;
            nbits_d    = '0;
          end else begin
            shift_d = cap_word;
            nbits_d = nbits_q + 1'b1;
          end
        end
        if (dec_readfifo && fifo_empty) underrun_d = 1'b1;
        if (wdog_trip) wdog_hit_d = 1'b1;
        if (dec_done || wdog_trip) state_d = ST_FLUSH;
      end
      ST_FLUSH: begin
        // Final word and status register here and appear together on the next cycle.
        if (pend_vld_q) begin
          msg_valid_d = 1'b1;
          msg_data_d  = pend_q;
          msg_last_d  = 1'b1;
        end else if (nbits_q != '0) begin
          msg_valid_d = 1'b1;
          msg_data_d  = shift_q;
          msg_last_d  = 1'b1;
        end
        stat_valid_d = 1'b1;
        stat_bits_d  = total_q;
        if (wdog_hit_q)      stat_err_d = CWD_WDOG;
        else if (underrun_q) stat_err_d = CWD_UNDERRUN;
        else if (!fifo_empty) stat_err_d = CWD_LEFTOVER;
        else                 stat_err_d = CWD_OK;
        shift_d    = '0;
        nbits_d    = '0;
        pend_vld_d = 1'b0;
        state_d    = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    dec_rst_b_d = (state_d == ST_START) || (state_d == ST_RUN);
    dec_start_d = (state_d == ST_START);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      drst_cnt_q   <= 1'b0;
      dec_rst_b_q  <= 1'b0;
      dec_start_q  <= 1'b1;
      shift_q      <= '0;
      nbits_q      <= '0;
      pend_q       <= '0;
      pend_vld_q   <= 1'b0;
      total_q      <= '0;
      underrun_q   <= 1'b0;
      wdog_hit_q   <= 1'b0;
      msg_valid_q  <= 1'b0;
      msg_data_q   <= '0;
      msg_last_q   <= 1'b0;
      stat_valid_q <= 1'b0;
      stat_bits_q  <= '0;
      stat_err_q   <= '0;
    end else begin
      state_q      <= state_d;
      drst_cnt_q   <= drst_cnt_d;
      dec_rst_b_q  <= dec_rst_b_d;
      dec_start_q  <= dec_start_d;
      shift_q      <= shift_d;
      nbits_q      <= nbits_d;
      pend_q       <= pend_d;
      pend_vld_q   <= pend_vld_d;
      total_q      <= total_d;
      underrun_q   <= underrun_d;
      wdog_hit_q   <= wdog_hit_d;
      msg_valid_q  <= msg_valid_d;
      msg_data_q   <= msg_data_d;
      msg_last_q   <= msg_last_d;
      stat_valid_q <= stat_valid_d;
      stat_bits_q  <= stat_bits_d;
      stat_err_q   <= stat_err_d;
    end
  end

  assign job_busy      = (state_q != ST_IDLE);
  assign dec_rst_b     = dec_rst_b_q;
  assign dec_start     = dec_start_q;
  assign dec_fifoempty = fifo_empty;
  assign msg_valid     = msg_valid_q;
  assign msg_data      = msg_data_q;
  assign msg_last      = msg_last_q;
  assign stat_valid    = stat_valid_q;
  assign stat_bits     = stat_bits_q;
  assign stat_err      = stat_err_q;

endmodule

// File: tb/tb_cwd_decode_ctrl.sv
// Self-checking bench for cwd_decode_ctrl; honours CWD_CTRL_WATCHDOG_EN like the design.
module tb_cwd_decode_ctrl;

  localparam int CW_W = 16;
  localparam int MSG_W = 8;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic job_start = 1'b0;
  logic job_busy;
  logic cw_valid = 1'b0;
  logic [CW_W-1:0] cw_data = '0;
  logic cw_ready;
  logic dec_rst_b, dec_start, dec_fifoempty;
  logic [CW_W-1:0] dec_cw_word;
  logic dec_readfifo = 1'b0, dec_bin_msg = 1'b0, dec_ready = 1'b0, dec_done = 1'b0;
  logic msg_valid, msg_last, stat_valid;
  logic [MSG_W-1:0] msg_data;
  logic [15:0] stat_bits;
  logic [1:0] stat_err;

  int total = 0;
  int bad = 0;
  logic [8:0] got_msg[$];
  logic [15:0] exp_fifo[$];

  cwd_decode_ctrl #(.CW_W(CW_W), .MSG_W(MSG_W), .FIFO_DEPTH(4), .WDOG_CYC(256)) dut (
    .clk(clk), .rst(rst), .job_start(job_start), .job_busy(job_busy),
    .cw_valid(cw_valid), .cw_data(cw_data), .cw_ready(cw_ready),
    .dec_rst_b(dec_rst_b), .dec_start(dec_start), .dec_fifoempty(dec_fifoempty),
    .dec_cw_word(dec_cw_word), .dec_readfifo(dec_readfifo), .dec_bin_msg(dec_bin_msg),
    .dec_ready(dec_ready), .dec_done(dec_done), .msg_valid(msg_valid), .msg_data(msg_data),
    .msg_last(msg_last), .stat_valid(stat_valid), .stat_bits(stat_bits), .stat_err(stat_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (msg_valid) got_msg.push_back({msg_last, msg_data});
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic start_job();
    int n;
    bit seen;
    job_start = 1'b1;
    @(negedge clk);
    job_start = 1'b0;
    n = 1;
    seen = 0;
    while (n <= 6 && !seen) begin
      if (dec_start) seen = 1;
      else begin
        @(negedge clk);
        n++;
      end
    end
    chk("start_latency", n, 3);
    chk("start_rst_b", dec_rst_b, 1);
    @(negedge clk);
    chk("start_pulse_end", dec_start, 0);
  endtask

  task automatic push_word(input logic [15:0] w);
    cw_valid = 1'b1;
    cw_data = w;
    if (cw_ready) exp_fifo.push_back(w);
    @(negedge clk);
    cw_valid = 1'b0;
  endtask

  task automatic pop_word(input string name);
    logic [15:0] e;
    dec_readfifo = 1'b1;
    @(negedge clk);
    dec_readfifo = 1'b0;
    if (exp_fifo.size() > 0) begin
      e = exp_fifo.pop_front();
      chk(name, dec_cw_word, e);
    end
  endtask

  task automatic send_bit(input logic b, input logic done);
    dec_ready = 1'b1;
    dec_bin_msg = b;
    dec_done = done;
    @(negedge clk);
    dec_ready = 1'b0;
    dec_done = 1'b0;
  endtask

  task automatic pulse_done();
    dec_done = 1'b1;
    @(negedge clk);
    dec_done = 1'b0;
  endtask

  // Waits for the status pulse; returns 0 if it never arrives within the budget.
  task automatic wait_stat(input int budget, output bit ok, output logic [15:0] bits, output logic [1:0] err);
    ok = 0;
    bits = '0;
    err = '0;
    for (int i = 0; i < budget && !ok; i++) begin
      if (stat_valid) begin
        ok = 1;
        bits = stat_bits;
        err = stat_err;
      end else @(negedge clk);
    end
  endtask

  // Reference: spec rules in terms of the transaction, not the datapath.
  function automatic logic [1:0] ref_err(input bit wd, input bit und, input int left);
    if (wd) return 2'b01;
    if (und) return 2'b11;
    if (left > 0) return 2'b10;
    return 2'b00;
  endfunction

  function automatic logic [8:0] ref_word(input int n, input logic [31:0] bits, input int w);
    logic [7:0] v;
    int nw;
    v = 8'h00;
    nw = (n + 7) / 8;
    for (int j = 0; j < 8; j++) begin
      if (w * 8 + j < n) v = v | (8'(bits[n - 1 - (w * 8 + j)]) << (7 - j));
    end
    return {(w == nw - 1) ? 1'b1 : 1'b0, v};
  endfunction

  task automatic run_job(input string tag, input int n, input logic [31:0] bits, input int npush,
                         input int npop, input bit und, input bit dwl);
    bit ok;
    logic [15:0] sb;
    logic [1:0] se;
    int nw;
    got_msg.delete();
    exp_fifo.delete();
    start_job();
    if (und) begin
      dec_readfifo = 1'b1;
      @(negedge clk);
      dec_readfifo = 1'b0;
    end
    for (int i = 0; i < npush; i++) push_word(16'($urandom));
    for (int i = 0; i < npop; i++) pop_word({tag, "_pop"});
    for (int k = 0; k < n; k++) begin
      if (k > 0) repeat ($urandom_range(0, 2)) @(negedge clk);
      send_bit(bits[n - 1 - k], dwl && (k == n - 1));
    end
    if (!(dwl && n > 0)) pulse_done();
    wait_stat(8, ok, sb, se);
    chk({tag, "_stat_seen"}, ok, 1);
    chk({tag, "_stat_bits"}, sb, n);
    chk({tag, "_stat_err"}, se, ref_err(0, und, npush - npop));
    chk({tag, "_idle_busy"}, job_busy, 0);
    chk({tag, "_idle_ready"}, cw_ready, 1);
    chk({tag, "_idle_empty"}, dec_fifoempty, 1);
    @(negedge clk);
    nw = (n + 7) / 8;
    chk({tag, "_msg_count"}, got_msg.size(), nw);
    for (int w = 0; w < nw && w < got_msg.size(); w++) chk({tag, "_msg_word"}, got_msg[w], ref_word(n, bits, w));
    $display("job %s n=%0d push=%0d pop=%0d und=%0d err=%0d words=%0d", tag, n, npush, npop, und, se, got_msg.size());
  endtask

  typedef struct {
    string tag;
    int n;
    logic [31:0] bits;
    int npush;
    int npop;
    bit und;
    bit dwl;
  } vec_t;

  vec_t vecs[7];

  initial begin
    bit ok;
    logic [15:0] sb;
    logic [1:0] se;
    int fall_n, stat_n;

    vecs[0] = '{"nine",     9, 32'b101100101, 0, 0, 0, 0};
    vecs[1] = '{"exact",    8, 32'hF0,        0, 0, 0, 0};
    vecs[2] = '{"empty",    0, 32'h0,         0, 0, 0, 0};
    vecs[3] = '{"leftover", 3, 32'b110,       3, 1, 0, 0};
    vecs[4] = '{"underrun", 5, 32'b10011,     1, 1, 1, 1};
    vecs[5] = '{"long",    17, 32'h1ACE5,     2, 2, 0, 1};
    vecs[6] = '{"prio",    16, 32'hA5C3,      2, 1, 1, 0};

    // Reset state
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_dec_rst_b", dec_rst_b, 0);
    chk("rst_dec_start", dec_start, 1);
    chk("rst_fifoempty", dec_fifoempty, 1);
    chk("rst_cw_ready", cw_ready, 1);
    chk("rst_job_busy", job_busy, 0);
    chk("rst_msg_valid", msg_valid, 0);
    chk("rst_stat_valid", stat_valid, 0);
    chk("rst_cw_word", dec_cw_word, 0);
    rst = 1'b0;
    @(negedge clk);
    $display("reset checked");

    // Spot checks of the spec's literal examples
    run_job(vecs[0].tag, vecs[0].n, vecs[0].bits, vecs[0].npush, vecs[0].npop, vecs[0].und, vecs[0].dwl);
    if (got_msg.size() == 2) begin
      chk("nine_w0_literal", got_msg[0], {1'b0, 8'hB2});
      chk("nine_w1_literal", got_msg[1], {1'b1, 8'h80});
    end else chk("nine_w_literal_count", got_msg.size(), 2);
    for (int v = 1; v < 7; v++)
      run_job(vecs[v].tag, vecs[v].n, vecs[v].bits, vecs[v].npush, vecs[v].npop, vecs[v].und, vecs[v].dwl);
    if (got_msg.size() == 2) chk("prio_w0_literal", got_msg[0], {1'b0, 8'hA5});

    // FIFO full, refused push during pop, ignored job_start in RUN
    got_msg.delete();
    exp_fifo.delete();
    start_job();
    job_start = 1'b1;
    @(negedge clk);
    job_start = 1'b0;
    repeat (3) begin
      chk("restart_ignored", dec_start, 0);
      @(negedge clk);
    end
    push_word(16'h1234);
    push_word(16'h5678);
    push_word(16'h9ABC);
    push_word(16'hDEF0);
    chk("full_cw_ready", cw_ready, 0);
    cw_valid = 1'b1;
    cw_data = 16'h5555;
    dec_readfifo = 1'b1;
    @(negedge clk);
    cw_valid = 1'b0;
    dec_readfifo = 1'b0;
    chk("full_pop_word", dec_cw_word, 16'h1234);
    chk("full_ready_back", cw_ready, 1);
    void'(exp_fifo.pop_front());
    pop_word("full_pop2");
    pop_word("full_pop3");
    pop_word("full_pop4");
    chk("full_refused_push", dec_fifoempty, 1);
    pulse_done();
    wait_stat(8, ok, sb, se);
    chk("full_stat_seen", ok, 1);
    chk("full_stat_err", se, ref_err(0, 0, 0));
    @(negedge clk);
    $display("fifo full sequence done");

    // Stalled decoder with one queued word
    got_msg.delete();
    start_job();
    push_word(16'hCAFE);
    fall_n = -1;
    stat_n = -1;
    se = 2'b00;
    for (int n = 0; n < 400 && stat_n < 0; n++) begin
      if (!dec_rst_b && fall_n < 0) fall_n = n;
      if (stat_valid) begin
        stat_n = n;
        se = stat_err;
      end else @(negedge clk);
    end
`ifdef CWD_CTRL_WATCHDOG_EN
    chk("wdog_rst_b_fall", fall_n, 256);
    chk("wdog_stat_cycle", stat_n, 257);
    chk("wdog_stat_err", se, ref_err(1, 0, 1));
    chk("wdog_fifo_flushed", dec_fifoempty, 1);
`else
    chk("nowdog_rst_b_held", dec_rst_b, 1);
    chk("nowdog_no_stat", stat_n, -1);
    pulse_done();
    wait_stat(8, ok, sb, se);
    chk("nowdog_stat_seen", ok, 1);
    chk("nowdog_stat_err", se, ref_err(0, 0, 1));
`endif
    @(negedge clk);
    chk("stall_no_msg", got_msg.size(), 0);
    $display("stall sequence done err=%0d", se);

    // Reset mid-job with a pending word: nothing may be reported
    got_msg.delete();
    start_job();
    for (int k = 0; k < 8; k++) send_bit(k[0], 1'b0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_busy", job_busy, 0);
    chk("midrst_rst_b", dec_rst_b, 0);
    wait_stat(6, ok, sb, se);
    chk("midrst_no_stat", ok, 0);
    chk("midrst_no_msg", got_msg.size(), 0);
    $display("mid-job reset done");

    // Randomized jobs against the reference model
    for (int r = 0; r < 12; r++) begin
      int n, np, nq;
      n = $urandom_range(0, 30);
      np = $urandom_range(0, 4);
      nq = $urandom_range(0, np);
      run_job("rand", n, $urandom, np, nq, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
